bus_master: RTL and testbench

- Initiator end of the serial bus; the counterpart to the memory slave.
- Accepts parallel read/write commands from a host, serializes the control frame onto `control`, and drives write data serially on `wD` with `valid`/`last`.
- Deserializes read data from `rD`, qualified by the slave's `ready`.
- Sits between the host/top module and the bus interconnect.

---
 rtl/serial_bus_pkg.sv | 39 +++
 rtl/ser_shift.sv | 64 ++++++
 rtl/bus_master.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_bus_master.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_bus_pkg.sv
// -----------------------------------------------------------------------------
// serial_bus_pkg
// Definitions shared by both ends of the serial bus (bus_master and the memory
// slave): frame start pattern, width helper functions and the master state enum.
// -----------------------------------------------------------------------------
package serial_bus_pkg;

    // Start-of-frame pattern, always the first three bits on control.
    localparam logic [2:0] START = 3'b111;

    // Bits needed to address one of 'slaves' slaves (at least one bit).
    function automatic int sid_w(input int slaves);
        return (slaves > 1) ? $clog2(slaves) : 1;
    endfunction

    // Bits needed to address 'depth' words of slave memory (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to hold a word count of 0..max_burst.
    function automatic int len_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // Frame = start(3) + slave id + rw(1) + burst(1) + address.
    function automatic int frame_len(input int sid_bits, input int addr_bits);
        return 3 + sid_bits + 2 + addr_bits;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FRAME = 3'd1,
        ACK   = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } bm_state_e;

endpackage

// File: rtl/ser_shift.sv
// -----------------------------------------------------------------------------
// ser_shift
// Loadable MSB-first shift register with a shift counter. Used as the frame
// serializer, the write-data serializer and the read-data deserializer.
//   clk, resetn  : clock, asynchronous active-low reset
//   load         : parallel load of load_val; clears the counter (wins over all)
//   load_val     : parallel word to serialize
//   shift_en     : shift left one place, serial_in enters at the LSB
//   serial_in    : bit entering the LSB on a shift
//   clr          : clear the counter (takes priority over the count increment)
//   serial_out   : current MSB (a flop output)
//   par_out      : full register contents
//   bit_cnt      : number of shifts since the last load/clear
// -----------------------------------------------------------------------------
module ser_shift #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          shift_en,
    input  logic          serial_in,
    input  logic          clr,
    output logic          serial_out,
    output logic [W-1:0]  par_out,
    output logic [CW-1:0] bit_cnt
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [W-1:0]  r_sr;
    logic [CW-1:0] r_cnt;

    // Shift register and shift counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_sr  <= load_val;
            r_cnt <= '0;
        end else begin
            if (shift_en) begin
                r_sr <= {r_sr[W-2:0], serial_in};
            end else begin
                r_sr <= r_sr;
            end
            if (clr) begin
                r_cnt <= '0;
            end else if (shift_en) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    assign serial_out = r_sr[W-1];
    assign par_out    = r_sr;
    assign bit_cnt    = r_cnt;

endmodule

// File: rtl/bus_master.sv
// -----------------------------------------------------------------------------
// bus_master
// Initiator end of the serial bus. Takes a parallel read/write command from the
// host, sends the control frame serially on 'control', waits for the slave's
// frame acknowledge (ready low then high), then either streams write words on
// wD/valid/last or collects read words from rD qualified by ready.
// Ports:
//   clk, resetn             : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   : host command handshake (ready only in IDLE)
//   cmd_rw, cmd_burst       : 1 = write / burst flag copied into the frame
//   cmd_slave, cmd_addr     : target slave and start address
//   cmd_len                 : word count (0 is treated as 1)
//   wr_data / wr_ack        : next write word, wr_ack pulses when it is taken
//   rd_data / rd_valid      : last received word and its update pulse
//   done / error            : completion pulse / acknowledge-timeout pulse
//   control                 : serial control frame (idles 0)
//   wD, valid, last         : serial write data, qualifier, final-word flag
//   rD, ready               : serial read data and slave handshake
// -----------------------------------------------------------------------------
module bus_master
    import serial_bus_pkg::*;
#(
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_rw,
    input  logic                              cmd_burst,
    input  logic [sid_w(SLAVES)-1:0]          cmd_slave,
    input  logic [addr_width(ADDR_DEPTH)-1:0] cmd_addr,
    input  logic [len_w(MAX_BURST)-1:0]       cmd_len,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_ack,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
    output logic                              done,
    output logic                              error,
    output logic                              control,
    output logic                              wD,
    output logic                              valid,
    output logic                              last,
    input  logic                              rD,
    input  logic                              ready
);

    localparam int SID_W      = sid_w(SLAVES);
    localparam int ADDR_WIDTH = addr_width(ADDR_DEPTH);
    localparam int LEN_W      = len_w(MAX_BURST);
    localparam int FRAME_LEN  = frame_len(SID_W, ADDR_WIDTH);
    localparam int FCW        = $clog2(FRAME_LEN + 1);
    localparam int DCW        = $clog2(DATA_WIDTH + 1);
    localparam int TW         = $clog2(TIMEOUT + 1);

    localparam logic [FCW-1:0]   FRAME_LAST = FCW'(FRAME_LEN - 1);
    localparam logic [DCW-1:0]   WORD_LAST  = DCW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0]    TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TMO_ONE    = TW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_TWO    = LEN_W'(2);

    bm_state_e r_state;
    bm_state_e w_state_nxt;

    logic                  r_cmd_ready;
    logic                  r_rw;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_words;
    logic [TW-1:0]         r_tmo;
    logic                  r_seen0;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_wr_ack;
    logic                  r_rd_valid;
    logic                  r_done;
    logic                  r_error;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_frame_load;
    logic                  w_frame_shift;
    logic                  w_frame_end;
    logic                  w_ack_done;
    logic                  w_timeout;
    logic                  w_wr_shift;
    logic                  w_wr_load;
    logic                  w_wr_word_end;
    logic                  w_rd_shift;
    logic                  w_rd_word_end;
    logic                  w_word_end;
    logic                  w_final;

    logic [FRAME_LEN-1:0]  w_frame_val;
    logic                  w_frame_ser;
    logic [FRAME_LEN-1:0]  w_frame_par;
    logic [FCW-1:0]        w_frame_cnt;
    logic                  w_wr_ser;
    logic [DATA_WIDTH-1:0] w_wr_par;
    logic [DCW-1:0]        w_wr_cnt;
    logic                  w_rd_ser;
    logic [DATA_WIDTH-1:0] w_rd_par;
    logic [DCW-1:0]        w_rd_cnt;
    logic                  w_unused_bits;

    assign w_frame_val = {START, cmd_slave, cmd_rw, cmd_burst, cmd_addr};

    // Frame serializer: zeros shift in behind the frame, so control falls to 0
    // on its own once the last bit has left.
    ser_shift #(.W(FRAME_LEN), .CW(FCW)) u_frame (
        .clk        (clk),
        .resetn     (resetn),
        .load       (w_frame_load),
        .load_val   (w_frame_val),
        .shift_en   (w_frame_shift),
        .serial_in  (1'b0),
        .clr        (w_frame_end),
        .serial_out (w_frame_ser),
        .par_out    (w_frame_par),
        .bit_cnt    (w_frame_cnt)
    );

    // Write serializer: after the final word it has shifted out completely,
    // leaving wD at 0 while idle.
    ser_shift #(.W(DATA_WIDTH), .CW(DCW)) u_wr (
        .clk        (clk),
        .resetn     (resetn),
        .load       (w_wr_load),
        .load_val   (wr_data),
        .shift_en   (w_wr_shift),
        .serial_in  (1'b0),
        .clr        (w_wr_word_end),
        .serial_out (w_wr_ser),
        .par_out    (w_wr_par),
        .bit_cnt    (w_wr_cnt)
    );

    // Read deserializer: only shifts on ready, counter cleared at each word end.
    ser_shift #(.W(DATA_WIDTH), .CW(DCW)) u_rd (
        .clk        (clk),
        .resetn     (resetn),
        .load       (1'b0),
        .load_val   ({DATA_WIDTH{1'b0}}),
        .shift_en   (w_rd_shift),
        .serial_in  (rD),
        .clr        (w_rd_word_end),
        .serial_out (w_rd_ser),
        .par_out    (w_rd_par),
        .bit_cnt    (w_rd_cnt)
    );

    assign w_unused_bits = ^{w_frame_par, w_wr_par, w_rd_ser};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-state control strobes for the shifters and the pulse outputs.
    always_comb begin
        w_frame_load  = 1'b0;
        w_frame_shift = 1'b0;
        w_frame_end   = 1'b0;
        w_ack_done    = 1'b0;
        w_timeout     = 1'b0;
        w_wr_shift    = 1'b0;
        w_rd_shift    = 1'b0;
        w_word_end    = 1'b0;
        case (r_state)
            IDLE: begin
                w_frame_load = cmd_valid & r_cmd_ready;
            end
            FRAME: begin
                w_frame_shift = 1'b1;
                w_frame_end   = (w_frame_cnt == FRAME_LAST);
            end
            ACK: begin
                // An acknowledge on the last allowed cycle still wins.
                w_ack_done = r_seen0 & ready;
                w_timeout  = ~(r_seen0 & ready) & (r_tmo == TMO_LAST);
            end
            WRITE: begin
                w_wr_shift = 1'b1;
                w_word_end = (w_wr_cnt == WORD_LAST);
            end
            READ: begin
                w_rd_shift = ready;
                w_word_end = ready & (w_rd_cnt == WORD_LAST);
            end
            default: begin
                w_frame_load = 1'b0;
            end
        endcase
        w_wr_word_end = w_word_end & (r_state == WRITE);
        w_rd_word_end = w_word_end & (r_state == READ);
        w_final       = w_word_end & (r_words == LEN_ONE);
        // A write word is fetched on entry to WRITE and at every non-final word end.
        w_wr_load     = (w_ack_done & r_rw) | (w_wr_word_end & ~w_final);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_frame_load) w_state_nxt = FRAME;
                else              w_state_nxt = IDLE;
            end
            FRAME: begin
                if (w_frame_end) w_state_nxt = ACK;
                else             w_state_nxt = FRAME;
            end
            ACK: begin
                if (w_ack_done)     w_state_nxt = r_rw ? WRITE : READ;
                else if (w_timeout) w_state_nxt = IDLE;
                else                w_state_nxt = ACK;
            end
            WRITE: begin
                if (w_final) w_state_nxt = IDLE;
                else         w_state_nxt = WRITE;
            end
            READ: begin
                if (w_final) w_state_nxt = IDLE;
                else         w_state_nxt = READ;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cmd_ready <= 1'b1;
            r_rw        <= 1'b0;
            r_len       <= '0;
            r_words     <= '0;
            r_tmo       <= '0;
            r_seen0     <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_valid     <= (w_state_nxt == WRITE);
            r_wr_ack    <= w_wr_load;
            r_rd_valid  <= w_rd_word_end;
            r_done      <= w_final;
            r_error     <= w_timeout;

            if (w_frame_load) begin
                r_rw  <= cmd_rw;
                r_len <= (cmd_len == '0) ? LEN_ONE : cmd_len;
            end else begin
                r_rw  <= r_rw;
                r_len <= r_len;
            end

            // Acknowledge tracking restarts on every entry to ACK.
            if (r_state == ACK) begin
                r_tmo   <= r_tmo + TMO_ONE;
                r_seen0 <= r_seen0 | ~ready;
            end else begin
                r_tmo   <= '0;
                r_seen0 <= 1'b0;
            end

            // r_words counts the current word too, so last follows it reaching 1.
            if (w_ack_done) begin
                r_words <= r_len;
                r_last  <= (r_len == LEN_ONE);
            end else if (w_word_end) begin
                r_words <= r_words - LEN_ONE;
                r_last  <= (r_words == LEN_TWO);
            end else begin
                r_words <= r_words;
                r_last  <= r_last;
            end

            if (w_rd_word_end) begin
                r_rd_data <= {w_rd_par[DATA_WIDTH-2:0], rD};
            end else begin
                r_rd_data <= r_rd_data;
            end
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign wr_ack    = r_wr_ack;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign done      = r_done;
    assign error     = r_error;
    assign control   = w_frame_ser;
    assign wD        = w_wr_ser;
    assign valid     = r_valid;
    assign last      = r_last;

endmodule

// File: tb/tb_bus_master.sv
// -----------------------------------------------------------------------------
// tb_bus_master
// Scoreboard bench for bus_master: expected write words and read words are
// queued when the stimulus is driven and compared when the DUT emits them.
// -----------------------------------------------------------------------------
module tb_bus_master;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } wexp_t;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic        cmd_burst;
    logic [1:0]  cmd_slave;
    logic [10:0] cmd_addr;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        error;
    logic        control;
    logic        wD;
    logic        valid;
    logic        last;
    logic        rD;
    logic        ready;

    bus_master dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_burst(cmd_burst), .cmd_slave(cmd_slave), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
        .control(control), .wD(wD), .valid(valid), .last(last),
        .rD(rD), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wexp_t       exp_wd_q[$];
    logic [31:0] exp_rd_q[$];
    logic [31:0] host_q[$];
    logic [31:0] wr_words[4];
    logic [31:0] rd_words[4];

    int n_cmp, n_bad, cyc;
    int n_valid, vfirst, n_done, done_cyc, n_errp, err_cyc;
    int n_wr_ack, n_rd_valid, n_rv_done, wcnt;
    bit vseen;
    logic [31:0] wbits;
    logic wl_and, wl_or;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_valid = 0; vseen = 0; vfirst = 0; n_done = 0; done_cyc = 0;
        n_errp = 0; err_cyc = 0; n_wr_ack = 0; n_rd_valid = 0; n_rv_done = 0;
        wcnt = 0; wbits = '0; wl_and = 1'b1; wl_or = 1'b0;
    endtask

    // One clock: wait for the falling edge, then run the monitors/host model.
    task automatic tick();
        wexp_t e;
        logic [31:0] r;
        @(negedge clk);
        cyc++;
        if (valid) begin
            if (!vseen) begin vseen = 1; vfirst = cyc; end
            n_valid++;
            wbits  = {wbits[30:0], wD};
            wl_and = wl_and & last;
            wl_or  = wl_or | last;
            wcnt++;
            if (wcnt == 32) begin
                chk("wd_avail", exp_wd_q.size() > 0, 1);
                if (exp_wd_q.size() > 0) begin
                    e = exp_wd_q.pop_front();
                    chk("wd_word", wbits, e.data);
                    chk("wd_last", {wl_and, wl_or}, {e.last, e.last});
                end
                wcnt = 0; wl_and = 1'b1; wl_or = 1'b0;
            end
        end
        if (wr_ack) begin
            n_wr_ack++;
            if (host_q.size() > 0) wr_data = host_q.pop_front();
        end
        if (rd_valid) begin
            n_rd_valid++;
            if (done) n_rv_done++;
            chk("rd_avail", exp_rd_q.size() > 0, 1);
            if (exp_rd_q.size() > 0) begin
                r = exp_rd_q.pop_front();
                chk("rd_data", rd_data, r);
            end
        end
        if (done)  begin n_done++; done_cyc = cyc; end
        if (error) begin n_errp++; err_cyc = cyc; end
    endtask

    // Drive one command and capture the 18-bit frame it produces.
    task automatic issue(input logic rw, input logic b, input logic [1:0] s,
                         input logic [10:0] a, input logic [4:0] l);
        logic [17:0] f;
        logic [17:0] fexp;
        fexp = {3'b111, s, rw, b, a};
        cmd_rw = rw; cmd_burst = b; cmd_slave = s; cmd_addr = a; cmd_len = l;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
        f = '0;
        f[0] = control;
        for (int i = 0; i < 17; i++) begin
            tick();
            f = {f[16:0], control};
        end
        chk("frame", f, fexp);
    endtask

    // Slave acknowledge: ready 0 during the first ACK cycle, 1 in the second.
    task automatic ack_hs();
        tick();
        chk("ctl_idle_after_frame", control, 0);
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
    endtask

    task automatic run_write(input logic b, input logic [1:0] s, input logic [10:0] a,
                             input logic [4:0] l, input int nw);
        clr_stats();
        for (int i = 0; i < nw; i++) exp_wd_q.push_back('{data: wr_words[i], last: (i == nw - 1)});
        wr_data = wr_words[0];
        for (int i = 1; i < nw; i++) host_q.push_back(wr_words[i]);
        issue(1'b1, b, s, a, l);
        ack_hs();
        wait_done(40 * nw + 20);
        chk("wr_done_cnt", n_done, 1);
        chk("wr_ack_cnt", n_wr_ack, nw);
        chk("wr_valid_cycles", n_valid, 32 * nw);
        chk("wr_span", done_cyc - vfirst, 32 * nw);
        chk("wr_queue_empty", exp_wd_q.size(), 0);
        tick();
        chk("wr_cmd_ready", cmd_ready, 1);
        chk("wr_valid_low", valid, 0);
    endtask

    // Serve one read word on rD; optionally insert a ready=0 cycle after each bit.
    task automatic send_word(input logic [31:0] d, input bit tog, input logic exp_last);
        logic la, lo;
        la = 1'b1; lo = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            la = la & last;
            lo = lo | last;
            rD = d[i]; ready = 1'b1;
            tick();
            if (tog) begin
                ready = 1'b0; rD = ~d[i];
                tick();
            end
        end
        ready = 1'b0;
        chk("rd_last", {la, lo}, {exp_last, exp_last});
    endtask

    task automatic run_read(input logic b, input logic [1:0] s, input logic [10:0] a,
                            input logic [4:0] l, input int nw, input bit tog);
        clr_stats();
        for (int i = 0; i < nw; i++) exp_rd_q.push_back(rd_words[i]);
        issue(1'b0, b, s, a, l);
        ack_hs();
        for (int w = 0; w < nw; w++) begin
            if (w > 0) tick();
            send_word(rd_words[w], tog, w == nw - 1);
        end
        wait_done(8);
        chk("rd_valid_cnt", n_rd_valid, nw);
        chk("rd_valid_with_done", n_rv_done, 1);
        chk("rd_done_cnt", n_done, 1);
        chk("rd_queue_empty", exp_rd_q.size(), 0);
        chk("rd_no_valid", n_valid, 0);
        tick();
        chk("rd_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        resetn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_burst = 1'b0;
        cmd_slave = '0; cmd_addr = '0; cmd_len = '0; wr_data = '0;
        rD = 1'b0; ready = 1'b0;
        clr_stats();
        repeat (3) @(negedge clk);
        chk("reset_outs", {cmd_ready, control, wD, valid, last, wr_ack, rd_valid, done, error}, 9'b1_0000_0000);
        chk("reset_rd_data", rd_data, 0);
        resetn = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);

        // Single write.
        wr_words[0] = 32'hA5A5_0001;
        run_write(1'b0, 2'd2, 11'd5, 5'd1, 1);

        // Burst write of three words.
        wr_words[0] = 32'h0000_0001; wr_words[1] = 32'h0000_0002; wr_words[2] = 32'h0000_0003;
        run_write(1'b1, 2'd1, 11'd10, 5'd3, 3);

        // Single read with ready toggling between bits.
        rd_words[0] = 32'hDEAD_BEEF;
        run_read(1'b0, 2'd1, 11'd100, 5'd1, 1, 1'b1);
        chk("rd_data_hold", rd_data, 32'hDEAD_BEEF);

        // Burst read of two words with a one-cycle gap.
        rd_words[0] = 32'h0123_4567; rd_words[1] = 32'h89AB_CDEF;
        run_read(1'b1, 2'd0, 11'd2047, 5'd2, 2, 1'b0);

        // No acknowledge: ready stuck high.
        clr_stats();
        ready = 1'b1;
        issue(1'b0, 1'b0, 2'd1, 11'd3, 5'd1);
        tick();
        vfirst = cyc;
        for (int i = 0; i < 100 && n_errp == 0; i++) tick();
        chk("tmo_error_cnt", n_errp, 1);
        chk("tmo_latency", err_cyc - vfirst, 64);
        chk("tmo_cmd_ready", cmd_ready, 1);
        chk("tmo_no_valid", n_valid, 0);
        chk("tmo_no_done", n_done, 0);
        ready = 1'b0;
        tick();

        // Reset in the middle of a write word.
        clr_stats();
        wr_words[0] = 32'h1234_5678;
        exp_wd_q.push_back('{data: wr_words[0], last: 1'b1});
        wr_data = wr_words[0];
        issue(1'b1, 1'b0, 2'd2, 11'd9, 5'd1);
        ack_hs();
        repeat (14) tick();
        chk("rst_bits_seen", wcnt, 15);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_outs", {cmd_ready, control, wD, valid, last, wr_ack, rd_valid, done, error}, 9'b1_0000_0000);
        chk("rst_mid_rd_data", rd_data, 0);
        exp_wd_q.delete();
        host_q.delete();
        clr_stats();
        tick();
        tick();
        chk("rst_no_done", n_done, 0);
        resetn = 1'b1;
        tick();

        // Command after reset with cmd_len = 0 (treated as one word).
        wr_words[0] = 32'hCAFE_F00D;
        run_write(1'b0, 2'd0, 11'd1, 5'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
